reg_file_multi: RTL
===================

// Module: reg_file_multi
// PURPOSE
//  Parametrised ALU operand register file; next generation of the 8-bit operand/result store.
//  Holds DEPTH registers of DATA_W bits. Two registered read ports feed ALU operands a/b.
//  Two write sources: an external operand load port and an ALU write-back port. Write-back
//  takes a 2*DATA_W result, stored as one register (narrow) or a lo/hi register pair (wide).
//  Per-register valid bits; y mirrors the most recent write-back low half.
// PARAMETERS
//  DATA_W   8   register width in bits (>=2)
//  DEPTH    8   number of registers (power of two, >=2)
//  ADDR_W   $clog2(DEPTH)   address width (derived; not overridden)
// PORTS
//  clock      in   1         rising-edge clock
//  reset      in   1         asynchronous, active-high reset
//  ld_en      in   1         external operand load strobe
//  ld_addr    in   ADDR_W    load target register
//  ld_data    in   DATA_W    load value
//  wb_en      in   1         ALU write-back strobe
//  wb_wide    in   1         1: write both halves (lo->wb_addr, hi->wb_addr+1); 0: lo half only
//  wb_addr    in   ADDR_W    write-back target register
//  wb_data    in   2*DATA_W  ALU result {hi,lo}
//  rd_addr_a  in   ADDR_W    operand A select
//  rd_addr_b  in   ADDR_W    operand B select
//  a          out  DATA_W    operand A (registered)
//  b          out  DATA_W    operand B (registered)
//  a_valid    out  1         register behind a has been written since reset
//  b_valid    out  1         register behind b has been written since reset
//  y          out  DATA_W    low half of last write-back (registered)
// BEHAVIOUR
//  - Reset (async, any time, incl. mid-write): all registers, valid bits, a, b, a_valid,
//    b_valid, y -> 0. First edge after reset deasserts behaves normally.
//  - Writes commit on the rising clock edge; a write sets the target register's valid bit.
//  - Wide write-back: hi half to (wb_addr+1) mod DEPTH; DEPTH-1 wraps to register 0.
//  - Same-edge conflict: write-back beats load on any shared register; the load to a
//    non-conflicting register still commits. Wide wb covering both addresses: wb wins both.
//  - Reads: a/b/a_valid/b_valid are sampled from rd_addr_* on each edge (1-cycle latency),
//    no enable; rd_addr_a == rd_addr_b is legal and gives identical values.
//  - y <= wb_data[DATA_W-1:0] on each edge with wb_en=1, else holds.
//  - No arithmetic performed; widths exact, no truncation except the lo/hi split.
// CONFIGURATION
//  REG_FILE_MULTI_BYPASS_EN defined: read ports forward same-edge writes. If a read
//    address matches a committing write (wb lo, wb hi, or load, with wb-over-load priority),
//    a/b and valid flags show the new value on that edge (data visible 1 cycle after write).
//  Undefined: reads sample pre-write contents; new data appears on a/b one edge later
//    (2 cycles after the write is presented).
// STRUCTURE
//  - Package reg_file_multi_pkg: default DATA_W/DEPTH constants; clog2 helper function;
//    write-source select encoding (SRC_NONE, SRC_LOAD, SRC_WB_LO, SRC_WB_HI).
//  - Sub-module reg_file_multi_bank: storage array + valid bits + per-register write decode
//    and priority; top holds read muxes, bypass logic, output registers and y.
// TESTING
//  1 reset=1 mid-run after loads -> all outputs 0 immediately (before next edge); a_valid=0.
//  2 Default params, ld 0xBD->r0, 0xBE->r1, 0x7F->r2 (cf. data 24'h7FBEBD); rd_a=0, rd_b=1
//    -> a=0xBD, b=0xBE, a_valid=b_valid=1; r3 read -> 0x00, valid 0.
//  3 wb_en=1, wb_wide=0, wb_addr=2, wb_data=16'h0035 -> r2=0x35, y=0x35, r3 unchanged.
//  4 wb_wide=1, wb_addr=7, wb_data=16'h12AB -> r7=0xAB, r0=0x12 (wrap), y=0xAB.
//  5 Same edge ld r4=0x11 and wb narrow r4=0x22 -> r4=0x22; wb wide addr 3 + ld r4 -> r4=hi.
//  6 rd_a=5 while writing r5=0x5A: BYPASS_EN -> a=0x5A next edge; else old value, 0x5A one edge later.

Source files
------------

// File: rtl/reg_file_multi_pkg.sv
// Shared constants and helpers for the ALU operand register file.
//   DEFAULT_DATA_W / DEFAULT_DEPTH : default register width and count
//   clog2()                        : address-width helper used to derive ADDR_W
//   wr_src_e                       : which source commits into a register on an edge
package reg_file_multi_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_DEPTH  = 8;

  typedef enum logic [1:0] {
    SRC_NONE  = 2'd0,
    SRC_LOAD  = 2'd1,
    SRC_WB_LO = 2'd2,
    SRC_WB_HI = 2'd3
  } wr_src_e;

  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/reg_file_multi_bank.sv
// Storage array, per-register valid bits and write decode for reg_file_multi.
// Write-back beats load on a shared register; a wide write-back puts the high half
// into (wb_addr_i + 1) mod DEPTH.
// Ports:
//   clock_i, reset_i            : clock, asynchronous active-high reset
//   ld_en_i/ld_addr_i/ld_data_i : external operand load
//   wb_en_i/wb_wide_i/wb_addr_i/wb_data_i : ALU write-back ({hi,lo})
//   mem_q_o / vld_q_o           : current register contents and valid bits
//   mem_d_o / vld_d_o           : contents and valid bits after this edge's writes
module reg_file_multi_bank
  import reg_file_multi_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = clog2(DEPTH)
) (
  input  logic                           clock_i,
  input  logic                           reset_i,
  input  logic                           ld_en_i,
  input  logic [ADDR_W-1:0]              ld_addr_i,
  input  logic [DATA_W-1:0]              ld_data_i,
  input  logic                           wb_en_i,
  input  logic                           wb_wide_i,
  input  logic [ADDR_W-1:0]              wb_addr_i,
  input  logic [2*DATA_W-1:0]            wb_data_i,
  output logic [DEPTH-1:0][DATA_W-1:0]   mem_q_o,
  output logic [DEPTH-1:0]               vld_q_o,
  output logic [DEPTH-1:0][DATA_W-1:0]   mem_d_o,
  output logic [DEPTH-1:0]               vld_d_o
);

  logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
  logic [DEPTH-1:0]             vld_q, vld_d;
  logic [ADDR_W-1:0]            wb_hi_addr;
  wr_src_e                      src_sel [DEPTH];

  // ADDR_W-wide add wraps DEPTH-1 back to register 0.
  assign wb_hi_addr = wb_addr_i + ADDR_W'(1);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      src_sel[i] = SRC_NONE;
      if (wb_en_i && (wb_addr_i == ADDR_W'(i)))
        src_sel[i] = SRC_WB_LO;
      else if (wb_en_i && wb_wide_i && (wb_hi_addr == ADDR_W'(i)))
        src_sel[i] = SRC_WB_HI;
      else if (ld_en_i && (ld_addr_i == ADDR_W'(i)))
        src_sel[i] = SRC_LOAD;
    end
  end

  always_comb begin
    mem_d = mem_q;
    vld_d = vld_q;
    for (int i = 0; i < DEPTH; i++) begin
      case (src_sel[i])
        SRC_LOAD:  begin mem_d[i] = ld_data_i;                   vld_d[i] = 1'b1; end
        SRC_WB_LO: begin mem_d[i] = wb_data_i[DATA_W-1:0];        vld_d[i] = 1'b1; end
        SRC_WB_HI: begin mem_d[i] = wb_data_i[2*DATA_W-1:DATA_W]; vld_d[i] = 1'b1; end
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      mem_q <= '0;
      vld_q <= '0;
    end else begin
      mem_q <= mem_d;
      vld_q <= vld_d;
    end
  end

  assign mem_q_o = mem_q;
  assign vld_q_o = vld_q;
  assign mem_d_o = mem_d;
  assign vld_d_o = vld_d;

endmodule

// File: rtl/reg_file_multi.sv
// Parametrised ALU operand register file: DEPTH registers of DATA_W bits, two
// registered read ports (a, b) with valid flags, external load and ALU write-back
// (narrow or wide lo/hi pair). y holds the low half of the most recent write-back.
// Optional feature macro: REG_FILE_MULTI_BYPASS_EN -- when defined, read ports see
// writes committing on the same edge; otherwise they sample pre-write contents.
// Ports:
//   clock_i, reset_i                      : clock, asynchronous active-high reset
//   ld_en_i, ld_addr_i, ld_data_i         : operand load
//   wb_en_i, wb_wide_i, wb_addr_i, wb_data_i : ALU write-back
//   rd_addr_a_i, rd_addr_b_i              : read selects
//   a_o, b_o, a_valid_o, b_valid_o        : registered operands and valid flags
//   y_o                                   : registered low half of last write-back
module reg_file_multi
  import reg_file_multi_pkg::*;
#(
  parameter  int DATA_W = DEFAULT_DATA_W,
  parameter  int DEPTH  = DEFAULT_DEPTH,
  localparam int ADDR_W = clog2(DEPTH)
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic                ld_en_i,
  input  logic [ADDR_W-1:0]   ld_addr_i,
  input  logic [DATA_W-1:0]   ld_data_i,
  input  logic                wb_en_i,
  input  logic                wb_wide_i,
  input  logic [ADDR_W-1:0]   wb_addr_i,
  input  logic [2*DATA_W-1:0] wb_data_i,
  input  logic [ADDR_W-1:0]   rd_addr_a_i,
  input  logic [ADDR_W-1:0]   rd_addr_b_i,
  output logic [DATA_W-1:0]   a_o,
  output logic [DATA_W-1:0]   b_o,
  output logic                a_valid_o,
  output logic                b_valid_o,
  output logic [DATA_W-1:0]   y_o
);

  logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d, rd_mem;
  logic [DEPTH-1:0]             vld_q, vld_d, rd_vld;

  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, y_q, y_d;
  logic              a_valid_q, a_valid_d, b_valid_q, b_valid_d;

  reg_file_multi_bank #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_bank (
    .clock_i   (clock_i),
    .reset_i   (reset_i),
    .ld_en_i   (ld_en_i),
    .ld_addr_i (ld_addr_i),
    .ld_data_i (ld_data_i),
    .wb_en_i   (wb_en_i),
    .wb_wide_i (wb_wide_i),
    .wb_addr_i (wb_addr_i),
    .wb_data_i (wb_data_i),
    .mem_q_o   (mem_q),
    .vld_q_o   (vld_q),
    .mem_d_o   (mem_d),
    .vld_d_o   (vld_d)
  );

`ifdef REG_FILE_MULTI_BYPASS_EN
  // Post-write view already carries wb-over-load priority from the bank.
  assign rd_mem = mem_d;
  assign rd_vld = vld_d;
  logic unused_q;
  assign unused_q = ^{mem_q, vld_q};
`else
  assign rd_mem = mem_q;
  assign rd_vld = vld_q;
  logic unused_d;
  assign unused_d = ^{mem_d, vld_d};
`endif

  always_comb begin
    a_d       = rd_mem[rd_addr_a_i];
    b_d       = rd_mem[rd_addr_b_i];
    a_valid_d = rd_vld[rd_addr_a_i];
    b_valid_d = rd_vld[rd_addr_b_i];
    y_d       = wb_en_i ? wb_data_i[DATA_W-1:0] : y_q;
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      a_q       <= '0;
      b_q       <= '0;
      a_valid_q <= 1'b0;
      b_valid_q <= 1'b0;
      y_q       <= '0;
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      a_valid_q <= a_valid_d;
      b_valid_q <= b_valid_d;
      y_q       <= y_d;
    end
  end

  assign a_o       = a_q;
  assign b_o       = b_q;
  assign a_valid_o = a_valid_q;
  assign b_valid_o = b_valid_q;
  assign y_o       = y_q;

endmodule
